// File: rtl/flit_mon_pkg.sv
// Shared types for the flit activity monitor.
// MAX_HD_EN adds the per-packet maximum Hamming distance to the report.
package flit_mon_pkg;

  typedef enum logic [1:0] {IDLE, RECV, GAP} state_e;

  // Width able to hold a popcount of a w-bit vector.
  function automatic int unsigned hd_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  localparam int unsigned FLIT_W_DEF = 46;
  localparam int unsigned CNT_W_DEF  = 8;
  localparam int unsigned TOG_W_DEF  = 16;

  // Report layout at default widths; the monitor re-declares it at its own parameter widths.
  typedef struct packed {
    logic [CNT_W_DEF-1:0]             flits;
    logic [TOG_W_DEF-1:0]             toggles;
    logic                             sat;
`ifdef MAX_HD_EN
    logic [hd_width(FLIT_W_DEF)-1:0]  max_hd;
`endif
  } rpt_t;

endpackage

// File: rtl/popcount.sv
// Combinational population count of a W-bit vector.
module popcount #(
  parameter int unsigned W = 46
) (
  input  logic [W-1:0]             vec,
  output logic [$clog2(W+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/flit_activity_monitor.sv
// Per-packet flit/toggle accounting with a one-entry report hold register.
// MAX_HD_EN adds rpt_max_hd (largest per-flit Hamming distance in the packet).
module flit_activity_monitor
  import flit_mon_pkg::*;
#(
  parameter int unsigned FLIT_W  = 46,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TOG_W   = 16,
  parameter int unsigned EOP_GAP = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flit_valid,
  input  logic [FLIT_W-1:0]             flit_data,
  output logic                          rpt_valid,
  input  logic                          rpt_ready,
  output logic [CNT_W-1:0]              rpt_flits,
  output logic [TOG_W-1:0]              rpt_toggles,
  output logic                          rpt_sat,
`ifdef MAX_HD_EN
  output logic [hd_width(FLIT_W)-1:0]   rpt_max_hd,
`endif
  output logic [15:0]                   pkt_count,
  output logic [7:0]                    drop_count,
  output logic                          busy
);

  localparam int unsigned HD_W = hd_width(FLIT_W);

  typedef struct packed {
    logic [CNT_W-1:0] flits;
    logic [TOG_W-1:0] toggles;
    logic             sat;
`ifdef MAX_HD_EN
    logic [HD_W-1:0]  max_hd;
`endif
  } acc_t;

  state_e            state_q, state_d;
  acc_t              acc_q, acc_d, rpt_q;
  logic [3:0]        idle_q, idle_d;
  logic [FLIT_W-1:0] prev_q;
  logic [HD_W-1:0]   hd;
  logic [TOG_W-1:0]  tog_base;
  logic [TOG_W:0]    tog_sum;
  logic              start, close, load;
  logic              rpt_valid_q;
  logic [15:0]       pkt_q;
  logic [7:0]        drop_q;

  popcount #(
    .W(FLIT_W)
  ) u_popcount (
    .vec  (flit_data ^ prev_q),
    .count(hd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    close   = 1'b0;
    unique case (state_q)
      IDLE: if (flit_valid) state_d = RECV;
      RECV: begin
        if (!flit_valid) begin
          if (EOP_GAP == 1) begin
            state_d = IDLE;
            close   = 1'b1;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (flit_valid) begin
          state_d = RECV;
        end else if (idle_q + 4'd1 == 4'(EOP_GAP)) begin
          state_d = IDLE;
          close   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  assign start = (state_q == IDLE);

  // Accumulator next state; a flit in IDLE starts a fresh packet.
  always_comb begin
    acc_d    = acc_q;
    idle_d   = idle_q;
    tog_base = start ? '0 : acc_q.toggles;
    tog_sum  = {1'b0, tog_base} + (TOG_W+1)'(hd);
    if (flit_valid) begin
      idle_d    = '0;
      acc_d.sat = start ? 1'b0 : acc_q.sat;
      if (start) begin
        acc_d.flits = CNT_W'(1);
      end else if (acc_q.flits == '1) begin
        acc_d.sat = 1'b1;
      end else begin
        acc_d.flits = acc_q.flits + CNT_W'(1);
      end
      if (tog_sum[TOG_W]) begin
        acc_d.toggles = '1;
        acc_d.sat     = 1'b1;
      end else begin
        acc_d.toggles = tog_sum[TOG_W-1:0];
      end
`ifdef MAX_HD_EN
      if (start || hd > acc_q.max_hd) acc_d.max_hd = hd;
`endif
    end else if (state_q == RECV) begin
      idle_d = 4'd1;
    end else if (state_q == GAP) begin
      idle_d = idle_q + 4'd1;
    end
  end

  // The hold register accepts a new report when empty or draining this cycle.
  assign load = close && (!rpt_valid_q || rpt_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      rpt_q       <= '0;
      idle_q      <= '0;
      prev_q      <= '0;
      rpt_valid_q <= 1'b0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else begin
      acc_q  <= acc_d;
      idle_q <= idle_d;
      if (flit_valid) prev_q <= flit_data;
      if (load) begin
        rpt_q       <= acc_q;
        rpt_valid_q <= 1'b1;
      end else if (rpt_ready) begin
        rpt_valid_q <= 1'b0;
      end
      if (close) pkt_q <= pkt_q + 16'd1;
      if (close && !load && drop_q != '1) drop_q <= drop_q + 8'd1;
    end
  end

  assign rpt_valid   = rpt_valid_q;
  assign rpt_flits   = rpt_q.flits;
  assign rpt_toggles = rpt_q.toggles;
  assign rpt_sat     = rpt_q.sat;
`ifdef MAX_HD_EN
  assign rpt_max_hd  = rpt_q.max_hd;
`endif
  assign pkt_count   = pkt_q;
  assign drop_count  = drop_q;

endmodule

// File: tb/tb_flit_activity_monitor.sv
// Directed bench: default monitor plus CNT_W=4 and TOG_W=6 variants on the same stream.
module tb_flit_activity_monitor;

  localparam logic [45:0] ONES = {46{1'b1}};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flit_valid = 1'b0;
  logic [45:0] flit_data = '0;
  logic        rpt_ready = 1'b1;

  logic        rpt_valid, rpt_sat, busy;
  logic [7:0]  rpt_flits, drop_count;
  logic [15:0] rpt_toggles, pkt_count;
  logic        c_valid, c_sat, c_busy;
  logic [3:0]  c_flits;
  logic [15:0] c_toggles, c_pkt;
  logic [7:0]  c_drop;
  logic        t_valid, t_sat, t_busy;
  logic [7:0]  t_flits, t_drop;
  logic [5:0]  t_toggles;
  logic [15:0] t_pkt;
`ifdef MAX_HD_EN
  logic [5:0]  rpt_max_hd, c_max_hd, t_max_hd;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int q_flits[$];
  int q_tog[$];

  always #5 clk = ~clk;

  flit_activity_monitor dut (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_data(flit_data),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_flits(rpt_flits),
    .rpt_toggles(rpt_toggles), .rpt_sat(rpt_sat),
`ifdef MAX_HD_EN
    .rpt_max_hd(rpt_max_hd),
`endif
    .pkt_count(pkt_count), .drop_count(drop_count), .busy(busy)
  );

  flit_activity_monitor #(.CNT_W(4)) dut_cnt (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_data(flit_data),
    .rpt_valid(c_valid), .rpt_ready(rpt_ready), .rpt_flits(c_flits),
    .rpt_toggles(c_toggles), .rpt_sat(c_sat),
`ifdef MAX_HD_EN
    .rpt_max_hd(c_max_hd),
`endif
    .pkt_count(c_pkt), .drop_count(c_drop), .busy(c_busy)
  );

  flit_activity_monitor #(.TOG_W(6)) dut_tog (
    .clk(clk), .rst(rst), .flit_valid(flit_valid), .flit_data(flit_data),
    .rpt_valid(t_valid), .rpt_ready(rpt_ready), .rpt_flits(t_flits),
    .rpt_toggles(t_toggles), .rpt_sat(t_sat),
`ifdef MAX_HD_EN
    .rpt_max_hd(t_max_hd),
`endif
    .pkt_count(t_pkt), .drop_count(t_drop), .busy(t_busy)
  );

  // Record every report transfer of the default instance.
  always @(negedge clk) begin
    if (rpt_valid && rpt_ready) begin
      q_flits.push_back(int'(rpt_flits));
      q_tog.push_back(int'(rpt_toggles));
    end
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [45:0] d);
    flit_valid = v;
    flit_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0);
  endtask

  task automatic do_reset();
    flit_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q_flits.delete();
    q_tog.delete();
  endtask

  // 0, 7, 14, ... 42 low ones, repeating every 7 flits.
  function automatic logic [45:0] shift_ones(input int k);
    logic [45:0] v;
    v = '0;
    for (int b = 0; b < 7 * (k % 7); b++) v[b] = 1'b1;
    return v;
  endfunction

  initial begin
    do_reset();
    check_eq("reset_valid", rpt_valid, 0);
    check_eq("reset_flits", rpt_flits, 0);
    check_eq("reset_pkt", pkt_count, 0);
    check_eq("reset_drop", drop_count, 0);
    check_eq("reset_busy", busy, 0);

    // Test 1: four full-swing flits, 46 toggles each.
    cyc(1'b1, ONES); cyc(1'b1, '0); cyc(1'b1, ONES); cyc(1'b1, '0);
    check_eq("t1_busy", busy, 1);
    idle(3);
    check_eq("t1_valid_early", rpt_valid, 0);
    idle(1);
    check_eq("t1_valid", rpt_valid, 1);
    check_eq("t1_flits", rpt_flits, 4);
    check_eq("t1_toggles", rpt_toggles, 184);
    check_eq("t1_sat", rpt_sat, 0);
    check_eq("t1_pkt", pkt_count, 1);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t5_tog_toggles", t_toggles, 63);
    check_eq("t5_tog_sat", t_sat, 1);
    check_eq("t5_tog_flits", t_flits, 4);
    check_eq("t1_cnt_sat", c_sat, 0);
`ifdef MAX_HD_EN
    check_eq("t6_max_hd", rpt_max_hd, 46);
`endif
    idle(1);
    check_eq("t1_valid_fall", rpt_valid, 0);

    // Test 2: ten 20-flit shifting-ones packets, 7-cycle gaps.
    do_reset();
    for (int p = 0; p < 10; p++) begin
      for (int k = 0; k < 20; k++) cyc(1'b1, shift_ones(k));
      idle(7);
    end
    check_eq("t2_nrep", q_flits.size(), 10);
    for (int p = 0; p < q_flits.size(); p++) begin
      check_eq($sformatf("t2_flits%0d", p), q_flits[p], 20);
      // First packet starts from prev=0; later ones start from 35 ones.
      check_eq($sformatf("t2_tog%0d", p), q_tog[p], (p == 0) ? 203 : 238);
    end
    check_eq("t2_pkt", pkt_count, 10);
    check_eq("t2_drop", drop_count, 0);

    // Test 3: a 3-cycle gap does not close the packet.
    do_reset();
    for (int k = 0; k < 5; k++) cyc(1'b1, 46'(k + 1));
    idle(3);
    for (int k = 0; k < 5; k++) cyc(1'b1, 46'(k + 1));
    idle(6);
    check_eq("t3_nrep", q_flits.size(), 1);
    if (q_flits.size() > 0) check_eq("t3_flits", q_flits[0], 10);
    check_eq("t3_pkt", pkt_count, 1);

    // Test 4: consumer stalled over three closes.
    do_reset();
    rpt_ready = 1'b0;
    for (int p = 1; p <= 3; p++) begin
      for (int k = 0; k < p; k++) cyc(1'b1, ONES >> k);
      idle(4);
    end
    check_eq("t4_valid", rpt_valid, 1);
    check_eq("t4_flits_held", rpt_flits, 1);
    check_eq("t4_tog_held", rpt_toggles, 46);
    check_eq("t4_drop", drop_count, 2);
    check_eq("t4_pkt", pkt_count, 3);
    rpt_ready = 1'b1;
    idle(1);
    check_eq("t4_valid_fall", rpt_valid, 0);
    check_eq("t4_nrep", q_flits.size(), 1);

    // Test 5: 20 flits into a 4-bit flit counter.
    do_reset();
    for (int k = 0; k < 20; k++) cyc(1'b1, (k % 2 == 0) ? ONES : '0);
    idle(4);
    check_eq("t5_cnt_valid", c_valid, 1);
    check_eq("t5_cnt_flits", c_flits, 15);
    check_eq("t5_cnt_sat", c_sat, 1);
    check_eq("t5_def_flits", rpt_flits, 20);
    check_eq("t5_def_sat", rpt_sat, 0);
    idle(2);

    // Test 6: reset mid-packet drops the partial packet.
    do_reset();
    for (int k = 0; k < 10; k++) cyc(1'b1, 46'(k * 3 + 1));
    do_reset();
    check_eq("t6_busy_rst", busy, 0);
    cyc(1'b1, ONES); cyc(1'b1, '0);
    idle(6);
    check_eq("t6_nrep", q_flits.size(), 1);
    if (q_flits.size() > 0) check_eq("t6_flits", q_flits[0], 2);
    check_eq("t6_pkt", pkt_count, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/flit_activity_monitor.md
Name: flit_activity_monitor

Overview:
Receive-side counterpart of the flit injector used for energy characterization. It observes the flit stream delivered to or from a datapath block such as the adder and finds packet boundaries from idle gaps. Per packet it accumulates the flit count, the total bit toggles (Hamming distance between consecutive flits) and status. It issues one packet report per packet over a valid/ready handshake, so switching activity can be logged per packet instead of being post-processed from VCD.

Parameters:
FLIT_W, 46, flit width in bits (two 23-bit operand halves)
CNT_W, 8, width of the per-packet flit counter (saturating)
TOG_W, 16, width of the per-packet toggle accumulator (saturating)
EOP_GAP, 4, consecutive idle cycles that close a packet (1..15)

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
flit_valid  in  1  flit_data is a flit this cycle
flit_data  in  FLIT_W  flit payload
rpt_valid  out  1  report available
rpt_ready  in  1  report consumer accepts
rpt_flits  out  CNT_W  flits in the reported packet
rpt_toggles  out  TOG_W  sum of Hamming distances in the packet
rpt_sat  out  1  a counter saturated in this packet
pkt_count  out  16  packets closed since reset, wraps modulo 2^16
drop_count  out  8  reports lost because the hold register was busy, saturating
busy  out  1  a packet is in progress (state RECV or GAP)

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - All outputs 0.
  - prev_flit register=0, so the first flit after reset is compared against all-zeros, matching the injector's start value.
- Every accepted flit (flit_valid=1):
  - hd = popcount(flit_data ^ prev_flit).
  - prev_flit <= flit_data.
  - prev_flit is never cleared between packets.
- FSM:
  - IDLE: on flit_valid go to RECV. Set flits=1, toggles=hd, sat=0.
  - RECV: on flit_valid, flits+=1 and toggles+=hd. On no flit, go to GAP with idle=1.
  - GAP:
    - flit_valid returns to RECV, clears idle and counts the flit into the same packet.
    - Otherwise idle+=1.
    - When idle reaches EOP_GAP, the packet closes: state goes to IDLE and pkt_count+=1 on that edge.
- Report hold register (one entry):
  - On close, if rpt_valid=0 or rpt_ready=1, load the report and assert rpt_valid on the next cycle.
  - Otherwise the new report is discarded and drop_count+=1. The held report stays stable.
- Handshake:
  - Transfer happens when rpt_valid && rpt_ready.
  - rpt_valid deasserts the cycle after a transfer unless a close coincides, in which case the new report is loaded with no bubble.
  - rpt_* hold stable while rpt_valid && !rpt_ready.
- Latency: rpt_valid rises one cycle after the EOP_GAP-th consecutive idle cycle.
- Saturation:
  - flits clamps at 2^CNT_W-1.
  - toggles clamps at 2^TOG_W-1.
  - Either clamp sets sat, which is reported as rpt_sat.
- Simultaneous events:
  - A flit arriving in the same cycle the GAP count would expire keeps the packet open.
  - A close in the same cycle as a report transfer loads the new report.
- Reset mid-packet: the partial packet is discarded. No report is produced and pkt_count is not incremented.
- All arithmetic is unsigned. hd width is clog2(FLIT_W+1). hd is zero-extended into the toggle adder.

Optional Feature:
MAX_HD_EN:
- When defined: adds output rpt_max_hd [clog2(FLIT_W+1)], the maximum per-flit hd within the packet.
  - Reset value 0.
  - Loaded with the rest of the report.
- When undefined: the port and its register are absent, with no logic cost.

Decomposition:
- Package flit_mon_pkg holds:
  - the state enum IDLE/RECV/GAP;
  - a function for the hd width;
  - the report struct {flits, toggles, sat[, max_hd]}.
- One sub-module, popcount: combinational, parameter W, input vector, output count. It is instantiated once on flit_data^prev_flit.

Test Plan:
1. Reset then 4 flits: all-ones(46), 0, all-ones, 0, followed by 4 idle cycles. Expect rpt_flits=4, rpt_toggles=184, rpt_sat=0, pkt_count=1. rpt_valid must rise exactly 1 cycle after the 4th idle cycle.
2. Injector pattern: 10 packets of 20 flits from the shifting-ones sequence starting at 0, with 7-cycle gaps. Expect 10 reports, each rpt_flits=20. rpt_toggles must match the golden popcount sum of the first packet, which is 7 per flit for flits 1-6. pkt_count=10, drop_count=0.
3. Gap of 3 idle cycles between two 5-flit bursts, then 4 idle cycles. Expect one report with rpt_flits=10.
4. Hold rpt_ready=0 across 3 packet closes. Expect the first report held stable, drop_count=2, pkt_count=3. Raising rpt_ready then gives one transfer and rpt_valid falls.
5. With CNT_W=4, send 20 flits. Expect rpt_flits=15 and rpt_sat=1. With TOG_W=6, send the test-1 flits; expect rpt_toggles=63 and rpt_sat=1.
6. Assert rst after 10 flits of a packet, release, then send a 2-flit packet. Expect exactly one report with rpt_flits=2 and pkt_count=1. With MAX_HD_EN defined, test 1 gives rpt_max_hd=46.
